// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode and ALU definitions for the multi-cycle MIPS core
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Anything outside the supported subset, including unknown R-type functs, halts the core.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) ? (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
                                : (op inside {OP_LW, OP_SW, OP_BEQ, OP_J});
    endfunction

    // 32-bit wrapping ALU; slt is a signed compare.
    function automatic logic [31:0] alu_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        return (fn == FN_SUB) ? a - b :
               (fn == FN_AND) ? a & b :
               (fn == FN_OR)  ? a | b :
               (fn == FN_SLT) ? {31'b0, $signed(a) < $signed(b)} :
                                a + b;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: register file with two asynchronous read ports and one synchronous write port
module mc_regfile #(
    parameter int NUM_REGS = 32,
    parameter int RW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] ra1,
    input  logic [RW-1:0] ra2,
    output logic [31:0]   rd1,
    output logic [31:0]   rd2,
    input  logic          we,
    input  logic [RW-1:0] wa,
    input  logic [31:0]   wd
);

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    // Writes to register 0 are dropped so it always reads as zero.
    always_comb begin
        regs_d = regs_q;
        if (we && wa != '0) regs_d[wa] = wd;
    end

    // Register storage, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end

    assign rd1 = regs_q[ra1];
    assign rd2 = regs_q[ra2];

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle MIPS-subset core with a single req/ack memory port
module multicycle_core
    import mc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                NUM_REGS = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int RW = $clog2(NUM_REGS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;

    logic              ack;
    logic [5:0]        op, fn;
    logic [31:0]       imm32, jump32, rd1, rd2, rf_wd;
    logic [ADDR_W-1:0] next_addr;
    logic [RW-1:0]     rf_wa;
    logic              rf_we;

    // An ack only counts while our own request is up; strays after reset are dropped.
    assign ack    = mem_ack && mem_req_q;
    assign op     = ir_q[31:26];
    assign fn     = ir_q[5:0];
    assign imm32  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign jump32 = (32'(pc_q) & 32'hF000_0000) | {4'h0, ir_q[25:0], 2'b00};

    assign rf_we = state_q == WB;
    assign rf_wa = (op == OP_RTYPE) ? ir_q[11 +: RW] : ir_q[16 +: RW];
    assign rf_wd = (op == OP_RTYPE) ? alu_q : mdr_q;

    mc_regfile #(.NUM_REGS(NUM_REGS), .RW(RW)) u_regfile (
        .clk  (clk),
        .rst_n(rst_n),
        .ra1  (ir_q[21 +: RW]),
        .ra2  (ir_q[16 +: RW]),
        .rd1  (rd1),
        .rd2  (rd2),
        .we   (rf_we),
        .wa   (rf_wa),
        .wd   (rf_wd)
    );

    // State and datapath registers; reset abandons any outstanding transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            tgt_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state sequencing; HALT is terminal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = ack ? DECODE : FETCH;
            DECODE:  state_d = is_legal(op, fn) ? EXEC : HALT;
            EXEC:    state_d = (op == OP_RTYPE) ? WB : (op == OP_LW || op == OP_SW) ? MEM : FETCH;
            MEM:     state_d = !ack ? MEM : (op == OP_SW) ? FETCH : WB;
            WB:      state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    // Datapath updates: IR/PC on fetch, operands and branch target on decode, ALU and jumps on exec.
    always_comb begin
        pc_d  = pc_q;
        tgt_d = tgt_q;
        ir_d  = ir_q;
        a_d   = a_q;
        b_d   = b_q;
        alu_d = alu_q;
        mdr_d = mdr_q;
        case (state_q)
            FETCH: begin
                ir_d = ack ? mem_rdata : ir_q;
                pc_d = ack ? pc_q + ADDR_W'(4) : pc_q;
            end
            DECODE: begin
                a_d   = rd1;
                b_d   = rd2;
                tgt_d = pc_q + ADDR_W'(imm32 << 2);
            end
            EXEC: begin
                alu_d = (op == OP_RTYPE) ? alu_op(fn, a_q, b_q) : a_q + imm32;
                pc_d  = (op == OP_BEQ && a_q == b_q) ? tgt_q :
                        (op == OP_J)                 ? jump32[ADDR_W-1:0] : pc_q;
            end
            MEM:     mdr_d = (ack && op == OP_LW) ? mem_rdata : mdr_q;
            default: ;
        endcase
    end

    // Memory port values are derived from the state being entered so they are registered and stable.
    always_comb begin
        next_addr   = (state_d == MEM) ? alu_d[ADDR_W-1:0] : pc_d;
        mem_req_d   = state_d == FETCH || state_d == MEM;
        mem_we_d    = state_d == MEM && op == OP_SW;
        mem_addr_d  = next_addr & ~ADDR_W'(3);
        mem_wdata_d = (state_d == MEM) ? b_q : '0;
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = state_q == HALT;
    assign pc_out    = pc_q;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: scoreboard bench for multicycle_core with a variable-latency memory model
module tb_multicycle_core;

    localparam int AW = 12;
    localparam logic [5:0] LW = 6'h23;
    localparam logic [5:0] SW = 6'h2B;
    localparam logic [31:0] BAD = 32'hFC00_0000;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            gap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          mem_req, mem_we, halted;
    logic          mem_ack = 1'b0;
    logic [AW-1:0] mem_addr, pc_out;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    logic [31:0] mem [1024];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          wait_cyc = 0;
    int          wcnt = 0;
    logic        stall = 1'b0;
    logic        stray = 1'b0;

    multicycle_core #(.ADDR_W(AW), .NUM_REGS(8), .RESET_PC(12'h000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .halted   (halted),
        .pc_out   (pc_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Memory responder: acks after wait_cyc extra cycles, optionally stalls or drives stray acks.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else if (!mem_req) begin
            mem_ack = stray;
            wcnt = 0;
        end else if (!stall && wcnt >= wait_cyc) begin
            mem_ack = 1'b1;
            mem_rdata = mem[mem_addr[AW-1:2]];
            wcnt = 0;
        end else begin
            mem_ack = 1'b0;
            wcnt++;
        end
    end

    function automatic logic [31:0] rr(input int s, input int t, input int d, input logic [5:0] f);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, f};
    endfunction

    function automatic logic [31:0] ii(input logic [5:0] op, input int s, input int t, input logic [15:0] imm);
        return {op, 5'(s), 5'(t), imm};
    endfunction

    function automatic logic [31:0] jj(input int addr);
        return {6'h02, 26'(addr >> 2)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic ex(input logic we, input int addr, input logic [31:0] data, input int gap);
        sb.push_back('{we, AW'(addr), data, gap});
    endtask

    task automatic ins(input int addr, input logic [31:0] w, input int gap);
        mem[addr >> 2] = w;
        ex(1'b0, addr, 32'h0, gap);
    endtask

    // Monitor: every completed transfer is popped from the scoreboard and compared.
    task automatic mon();
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && mem_req && mem_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got we=%0b addr=%h, want none", mem_we, mem_addr);
                end else begin
                    e = sb.pop_front();
                    check("xfer_we", 32'(mem_we), 32'(e.we));
                    check("xfer_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) check("xfer_wdata", mem_wdata, e.data);
                    if (e.gap >= 0) check("xfer_gap", 32'(cyc - last_cyc), 32'(e.gap));
                end
                if (mem_we) mem[mem_addr[AW-1:2]] = mem_wdata;
                last_cyc = cyc;
            end
        end
    endtask

    task automatic rst_lo();
        #2 rst_n = 1'b0;
        stall = 1'b0;
        stray = 1'b0;
        wait_cyc = 0;
        sb.delete();
        foreach (mem[i]) mem[i] = '0;
        @(posedge clk);
        #2;
    endtask

    task automatic go();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Wait for the scoreboard to empty, then stall memory so nothing further completes.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        stall = 1'b1;
        check("drain_left", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    task automatic halt_chk(input logic [AW-1:0] pc);
        int n;
        @(negedge clk);
        check("halt_in_decode", 32'(halted), 32'h0);
        @(negedge clk);
        check("halted", 32'(halted), 32'h1);
        check("halt_pc", 32'(pc_out), 32'(pc));
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req) n++;
        end
        check("halt_no_req", 32'(n), 32'h0);
    endtask

    initial begin
        fork
            mon();
        join_none

        // ALU ops, r0 discard, zero-wait timing, halt at end
        rst_lo();
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_pc", 32'(pc_out), 32'h0);
        mem['h100 >> 2] = 32'd5;
        mem['h104 >> 2] = 32'd7;
        ins('h00, ii(LW, 0, 1, 16'h100), -1);  ex(1'b0, 'h100, 0, 3);
        ins('h04, ii(LW, 0, 2, 16'h104), 2);   ex(1'b0, 'h104, 0, 3);
        ins('h08, rr(1, 2, 3, 6'h20), 2);
        ins('h0C, rr(1, 2, 4, 6'h22), 4);
        ins('h10, rr(1, 2, 5, 6'h24), 4);
        ins('h14, rr(1, 2, 6, 6'h25), 4);
        ins('h18, rr(4, 1, 7, 6'h2A), 4);
        ins('h1C, rr(1, 2, 0, 6'h20), 4);
        ins('h20, ii(SW, 0, 3, 16'h108), 4);  ex(1'b1, 'h108, 32'd12, 3);
        ins('h24, ii(SW, 0, 4, 16'h10C), 1);  ex(1'b1, 'h10C, 32'hFFFF_FFFE, 3);
        ins('h28, ii(SW, 0, 5, 16'h110), 1);  ex(1'b1, 'h110, 32'd5, 3);
        ins('h2C, ii(SW, 0, 6, 16'h114), 1);  ex(1'b1, 'h114, 32'd7, 3);
        ins('h30, ii(SW, 0, 7, 16'h118), 1);  ex(1'b1, 'h118, 32'd1, 3);
        ins('h34, ii(SW, 0, 0, 16'h11C), 1);  ex(1'b1, 'h11C, 32'd0, 3);
        ins('h38, rr(1, 4, 7, 6'h2A), 1);
        ins('h3C, ii(SW, 0, 7, 16'h120), 4);  ex(1'b1, 'h120, 32'd0, 3);
        ins('h40, BAD, 1);
        go();
        drain(500);
        halt_chk(12'h044);

        // sw/lw with 3 wait cycles per transfer, illegal funct halts
        rst_lo();
        wait_cyc = 3;
        mem['h104 >> 2] = 32'd7;
        ins('h00, jj('h40), -1);
        ins('h40, ii(LW, 0, 2, 16'h104), 6);  ex(1'b0, 'h104, 0, 6);
        ins('h44, ii(SW, 0, 2, 16'h008), 5);  ex(1'b1, 'h008, 32'd7, 6);
        ins('h48, ii(LW, 0, 4, 16'h008), 4);  ex(1'b0, 'h008, 0, 6);
        ins('h4C, ii(SW, 0, 4, 16'h10C), 5);  ex(1'b1, 'h10C, 32'd7, 6);
        ins('h50, rr(1, 2, 3, 6'h21), 4);
        go();
        drain(500);
        halt_chk(12'h054);

        // beq to itself loops every 3 cycles without halting
        rst_lo();
        ins('h00, jj('h10), -1);
        ins('h10, ii(6'h04, 1, 1, 16'hFFFF), 3);
        repeat (4) ex(1'b0, 'h10, 0, 3);
        go();
        drain(500);
        repeat (3) @(negedge clk);
        check("beq_pc", 32'(pc_out), 32'h010);
        check("beq_not_halted", 32'(halted), 32'h0);

        // illegal opcode at 0x20
        rst_lo();
        ins('h00, jj('h20), -1);
        ins('h20, BAD, 3);
        go();
        drain(500);
        halt_chk(12'h024);

        // reset while a fetch waits for ack, then a stray ack right after release
        rst_lo();
        ins('h00, jj('h30), -1);
        go();
        drain(500);
        repeat (4) @(negedge clk);
        check("wait_req", 32'(mem_req), 32'h1);
        check("wait_addr", 32'(mem_addr), 32'h030);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(mem_req), 32'h0);
        check("async_rst_addr", 32'(mem_addr), 32'h0);
        check("async_rst_pc", 32'(pc_out), 32'h0);
        mem['h30 >> 2] = BAD;
        ex(1'b0, 'h00, 0, -1);
        ex(1'b0, 'h30, 0, 3);
        stall = 1'b0;
        stray = 1'b1;
        go();
        drain(500);
        halt_chk(12'h034);

        // r9 aliases r1 with 8 registers; PC wraps 0xFFC -> 0x000
        rst_lo();
        mem['h100 >> 2] = 32'h55;
        ins('h00, ii(LW, 0, 9, 16'h100), -1);  ex(1'b0, 'h100, 0, 3);
        ins('h04, ii(SW, 0, 1, 16'h104), 2);   ex(1'b1, 'h104, 32'h55, 3);
        ins('h08, jj('hFFC), 1);
        ins('hFFC, ii(SW, 0, 9, 16'h108), 3);  ex(1'b1, 'h108, 32'h55, 3);
        ex(1'b0, 'h000, 0, 1);
        go();
        drain(500);
        @(negedge clk);
        check("wrap_pc", 32'(pc_out), 32'h004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
